// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and the load/store path. One transaction at a time on a req/ack memory bus.
// Data has priority; a starvation counter bounds how long fetch can wait.
// Optional build macro MEM_ARB_MISALIGN_CHK_EN: screens data accesses for
// illegal byte enables or misalignment and answers them locally with d_err.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   // fetch requester
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_done,
   output logic [DATA_W-1:0]   if_rdata,
   // load/store requester
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_done,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   // memory port
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_ack,
   input  logic [DATA_W-1:0]   m_rdata,
   // pipeline stall
   output logic                stall
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, D_ERR} state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             if_elig, d_elig, grant_d, grant_if, d_bad;

   // A requester still holding req in its own done cycle is not re-granted
   always_comb begin
      if_elig  = if_req & ~if_done;
      d_elig   = d_req & ~d_done;
      grant_d  = (state == IDLE) & d_elig & ((starve_cnt < LIM) | ~if_elig);
      grant_if = (state == IDLE) & if_elig & ~grant_d;
   end

`ifdef MEM_ARB_MISALIGN_CHK_EN
   logic d_err_q;

   // Natural alignment per access size; any other enable pattern is illegal
   always_comb begin
      d_bad = 1'b1;
      case (d_be)
         BE_W'(8'h01): d_bad = 1'b0;
         BE_W'(8'h03): d_bad = d_addr[0];
         BE_W'(8'h0F): d_bad = |d_addr[1:0];
         BE_W'(8'hFF): d_bad = |d_addr[2:0];
         default:      d_bad = 1'b1;
      endcase
   end

   assign d_err = d_err_q;
`else
   assign d_bad = 1'b0;
   assign d_err = 1'b0;
`endif

   assign stall = (if_req & ~if_done) | (d_req & ~d_done);

   // Starvation counter: counts data wins while fetch is waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!if_req || grant_if)
         starve_cnt <= '0;
      else if (grant_d && starve_cnt < LIM)
         starve_cnt <= starve_cnt + CNT_W'(1);
   end

   // Port FSM: grant, hold the registered command until ack, pulse done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_be     <= '0;
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
         d_err_q  <= 1'b0;
`endif
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
         d_err_q <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (grant_d) begin
                  if (d_bad) begin
                     state <= D_ERR;
                  end else begin
                     state   <= D_BUSY;
                     m_req   <= 1'b1;
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     m_be    <= d_be;
                  end
               end else if (grant_if) begin
                  state  <= IF_BUSY;
                  m_req  <= 1'b1;
                  m_we   <= 1'b0;
                  m_addr <= if_addr;
                  m_be   <= '1;
               end
            end
            IF_BUSY: begin
               if (m_ack) begin
                  m_req    <= 1'b0;
                  if_rdata <= m_rdata;
                  if_done  <= 1'b1;
                  state    <= IDLE;
               end
            end
            D_BUSY: begin
               if (m_ack) begin
                  m_req  <= 1'b0;
                  if (!m_we)
                     d_rdata <= m_rdata;
                  d_done <= 1'b1;
                  state  <= IDLE;
               end
            end
            D_ERR: begin
               d_done  <= 1'b1;
`ifdef MEM_ARB_MISALIGN_CHK_EN
               d_err_q <= 1'b1;
`endif
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int BW  = DW / 8;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we, m_ack;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata, m_rdata;
   logic [BW-1:0] d_be;
   logic          if_done, d_done, d_err, m_req, m_we, stall;
   logic [DW-1:0] if_rdata, d_rdata, m_wdata;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_be;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the port (0 free, 1 fetch, 2 data, 3 error
   // reply), how many data wins fetch has sat through, and expected outputs.
   int            owner, waits;
   logic          e_m_req, e_m_we, e_if_done, e_d_done, e_d_err;
   logic [AW-1:0] e_m_addr;
   logic [DW-1:0] e_m_wdata, e_if_rdata, e_d_rdata;
   logic [BW-1:0] e_m_be;

   // Environment knobs
   int            ack_delay, wcnt;
   bit            rnd_mode, rearm_d;
   logic [DW-1:0] rd_val;
   logic [7:0]    be_tab [0:4] = '{8'h01, 8'h03, 8'h0F, 8'hFF, 8'h07};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

`ifdef MEM_ARB_MISALIGN_CHK_EN
   // Legal = contiguous low-aligned enables of size 1/2/4/8, address a multiple of size
   function automatic bit legal(input logic [7:0] be, input logic [63:0] a);
      int n;
      n = $countones(be);
      if (n != 1 && n != 2 && n != 4 && n != 8) return 1'b0;
      if (int'(be) != (1 << n) - 1) return 1'b0;
      return (a % 64'(n)) == 64'd0;
   endfunction
`endif

   task automatic model_reset();
      owner = 0; waits = 0;
      e_m_req = 0; e_m_we = 0; e_m_addr = '0; e_m_wdata = '0; e_m_be = '0;
      e_if_done = 0; e_d_done = 0; e_d_err = 0; e_if_rdata = '0; e_d_rdata = '0;
      wcnt = 0;
   endtask

   task automatic chk_outputs(input string pfx);
      chk({pfx, "_m_req"},    m_req,    e_m_req);
      chk({pfx, "_m_we"},     m_we,     e_m_we);
      chk({pfx, "_m_addr"},   m_addr,   e_m_addr);
      chk({pfx, "_m_wdata"},  m_wdata,  e_m_wdata);
      chk({pfx, "_m_be"},     m_be,     e_m_be);
      chk({pfx, "_if_done"},  if_done,  e_if_done);
      chk({pfx, "_if_rdata"}, if_rdata, e_if_rdata);
      chk({pfx, "_d_done"},   d_done,   e_d_done);
      chk({pfx, "_d_rdata"},  d_rdata,  e_d_rdata);
      chk({pfx, "_d_err"},    d_err,    e_d_err);
   endtask

   // One clock: check stall on current inputs, advance the model, check outputs
   task automatic cyc();
      logic nif, nd, ne;
      bit   fe, de, ok;
      int   nwaits;
      #1;
      chk("stall", stall, (if_req & ~e_if_done) | (d_req & ~e_d_done));
      nif = 0; nd = 0; ne = 0; nwaits = waits;
      fe = if_req & ~e_if_done;
      de = d_req & ~e_d_done;
      case (owner)
         0: begin
            if (de && (waits < LIM || !fe)) begin
               if (if_req) nwaits = (waits < LIM) ? waits + 1 : LIM;
`ifdef MEM_ARB_MISALIGN_CHK_EN
               ok = legal(d_be, d_addr);
`else
               ok = 1'b1;
`endif
               if (ok) begin
                  owner = 2; e_m_req = 1; e_m_we = d_we; e_m_addr = d_addr;
                  e_m_wdata = d_wdata; e_m_be = d_be;
               end else begin
                  owner = 3;
               end
            end else if (fe) begin
               nwaits = 0; owner = 1;
               e_m_req = 1; e_m_we = 0; e_m_addr = if_addr; e_m_be = '1;
            end
         end
         1: if (m_ack) begin e_m_req = 0; e_if_rdata = m_rdata; nif = 1; owner = 0; end
         2: if (m_ack) begin
               e_m_req = 0; nd = 1; owner = 0;
               if (!e_m_we) e_d_rdata = m_rdata;
            end
         default: begin nd = 1; ne = 1; owner = 0; end
      endcase
      if (!if_req) nwaits = 0;
      @(posedge clk); #1;
      waits = nwaits; e_if_done = nif; e_d_done = nd; e_d_err = ne;
      chk_outputs("cyc");
   endtask

   // Drive requester and memory inputs for the coming cycle
   task automatic env_step();
      m_ack = 1'b0;
      if (e_m_req) begin
         if (wcnt >= ack_delay) begin
            m_ack = 1'b1; m_rdata = rd_val; wcnt = 0;
            if (rnd_mode) begin
               ack_delay = $urandom_range(0, 3);
               rd_val = {$urandom, $urandom};
            end
         end else begin
            wcnt++;
         end
      end else if (rnd_mode && $urandom_range(0, 7) == 0) begin
         m_ack = 1'b1; m_rdata = {$urandom, $urandom};   // stray ack, must be dropped
      end
      if (rnd_mode) begin
         if (!if_req || e_if_done) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = {$urandom, $urandom} & ~64'h7;
         end
         if (!d_req || e_d_done) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1);
            d_be    = be_tab[$urandom_range(0, 4)];
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
         end
      end else begin
         if (e_if_done) if_req = 1'b0;
         if (e_d_done) d_req = 1'b0;
         else if (rearm_d && !d_req) d_req = 1'b1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin env_step(); cyc(); end
   endtask

   initial begin
      int   dg, npulse;
      bit   fseen;
      logic prv;

      rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; m_ack = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
      ack_delay = 0; rnd_mode = 0; rearm_d = 0; rd_val = '0;
      model_reset();

      // Reset state
      #2;
      chk_outputs("reset");
      chk("reset_stall", stall, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(2);

      // Fetch only, ack one cycle after m_req
      if_req = 1; if_addr = 64'h1000; rd_val = 64'hDEADBEEF;
      cyc();
      chk("fetch_m_req_n1", m_req, 1'b1);
      run(1);
      chk("fetch_done_n2", if_done, 1'b1);
      chk("fetch_rdata", if_rdata, 64'hDEADBEEF);
      run(1);
      chk("fetch_stall_n3", stall, 1'b0);
      run(2);

      // Simultaneous requests: data store first, fetch taken in the d_done cycle
      if_req = 1; if_addr = 64'h3000;
      d_req = 1; d_we = 1; d_be = 8'hFF; d_addr = 64'h2008; d_wdata = 64'h0123456789ABCDEF;
      rd_val = 64'h5555AAAA5555AAAA;
      cyc();
      chk("sim_m_we", m_we, 1'b1);
      chk("sim_m_be", m_be, 8'hFF);
      chk("sim_m_addr", m_addr, 64'h2008);
      for (int i = 0; i < 20 && !e_d_done; i++) begin env_step(); cyc(); end
      chk("sim_d_done", d_done, 1'b1);
      run(1);
      chk("sim_if_grant_addr", m_addr, 64'h3000);
      chk("sim_if_grant_req", m_req, 1'b1);
      run(6);

      // Fetch held while data re-requests after every completion
      rearm_d = 1; dg = 0; fseen = 0; prv = m_req;
      d_req = 1; d_we = 0; d_addr = 64'h4000; d_be = 8'hFF;
      if_req = 1; if_addr = 64'h5000; rd_val = 64'h77;
      for (int i = 0; i < 60 && !fseen; i++) begin
         if (i > 0) env_step();
         cyc();
         if (m_req && !prv && m_addr == 64'h4000) dg++;
         if (m_req && !prv && m_addr == 64'h5000) fseen = 1;
         prv = m_req;
      end
      chk("starve_fetch_granted", fseen, 1'b1);
      chk("starve_bound", (dg >= 1 && dg <= LIM), 1'b1);
      rearm_d = 0;
      run(12);

      // Wait states: ack five cycles late, single done pulse
      ack_delay = 5; rd_val = 64'hCAFEF00D12345678; npulse = 0;
      d_req = 1; d_we = 0; d_addr = 64'h6000; d_be = 8'hFF;
      cyc();
      npulse += d_done;
      for (int i = 0; i < 12; i++) begin env_step(); cyc(); npulse += d_done; end
      chk("ws_single_done", npulse, 1);
      chk("ws_rdata", d_rdata, 64'hCAFEF00D12345678);
      ack_delay = 0;
      run(2);

      // Misaligned word access
      d_req = 1; d_we = 0; d_be = 8'h0F; d_addr = 64'h2002; rd_val = 64'h99;
      cyc();
`ifdef MEM_ARB_MISALIGN_CHK_EN
      chk("mis_m_req", m_req, 1'b0);
`else
      chk("mis_m_req", m_req, 1'b1);
`endif
      for (int i = 0; i < 10 && !e_d_done; i++) begin env_step(); cyc(); end
      chk("mis_d_done", d_done, 1'b1);
`ifdef MEM_ARB_MISALIGN_CHK_EN
      chk("mis_d_err", d_err, 1'b1);
`else
      chk("mis_d_err", d_err, 1'b0);
`endif
      run(2);

      // Reset in the middle of a data access, then a late ack
      ack_delay = 5;
      d_req = 1; d_we = 0; d_addr = 64'h7000; d_be = 8'hFF;
      cyc();
      run(1);
      chk("rst_busy_m_req", m_req, 1'b1);
      #2;
      rst_n = 0; d_req = 0; if_req = 0;
      #1;
      model_reset();
      chk_outputs("rst_mid");
      @(posedge clk); #1;
      rst_n = 1; ack_delay = 0;
      m_ack = 1; m_rdata = 64'hBAD;
      cyc();
      m_ack = 0;
      cyc();
      chk("rst_late_ack_no_done", d_done, 1'b0);
      run(2);

      // Randomized traffic
      rnd_mode = 1; ack_delay = $urandom_range(0, 3); rd_val = {$urandom, $urandom};
      run(600);
      rnd_mode = 0; if_req = 0; d_req = 0; ack_delay = 0;
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
